// File: rtl/user_bitrev.sv
// OBI subordinate that bit-reverses the low W bits of 32-bit operands.
// Operands queue in an input FIFO, a bit-serial engine reverses them, results queue for register reads.

package user_bitrev_pkg;

    typedef struct packed {
        int unsigned DataWidth;
        int unsigned AddrWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiCfgDefault = '{DataWidth: 32, AddrWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef obi_req_t sbr_obi_req_t;
    typedef obi_rsp_t sbr_obi_rsp_t;

endpackage

// Small synchronous FIFO; full/empty are registered and a next-cycle empty flag is exported
// so downstream flags can be registered without a decode glitch.
module bitrev_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic [$clog2(Depth):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_nxt
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(Depth));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata     = mem_q[rptr_q];
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = (count_d == '0);

endmodule

// Engine FSM:
//   state    | meaning
//   ST_IDLE  | waiting for an operand and a free result slot
//   ST_SHIFT | moving one operand bit per cycle into the accumulator
//   ST_PUSH  | writing the accumulator into the result FIFO
module user_bitrev #(
    parameter user_bitrev_pkg::obi_cfg_t ObiCfg = user_bitrev_pkg::ObiCfgDefault,
    parameter type obi_req_t = user_bitrev_pkg::obi_req_t,
    parameter type obi_rsp_t = user_bitrev_pkg::obi_rsp_t,
    parameter int unsigned Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned IW = ObiCfg.IdWidth;
    localparam int unsigned CW = $clog2(Depth) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PUSH  = 2'd2
    } state_t;

    logic          req, we;
    logic [1:0]    sel;
    logic [DW-1:0] wdata;
    logic          unused_bits;

    assign req   = obi_req_i.req;
    assign we    = obi_req_i.a.we;
    assign sel   = obi_req_i.a.addr[3:2];
    assign wdata = obi_req_i.a.wdata;
    assign unused_bits = ^{obi_req_i.a.be, obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0]};

    logic [4:0] wsel_q;
    logic       irq_en_q, irq_en_d;
    logic       ctrl_wr;

    logic [DW-1:0] in_head, res_head;
    logic [CW-1:0] in_count, res_count;
    logic          in_full, in_empty, res_full, res_empty, res_empty_nxt;
    logic          in_empty_nxt_unused;
    logic          in_wr, in_push, in_pop, res_pop;

    state_t        state_q, state_d;
    logic          load, shift, res_push, busy, can_start;
    logic [DW-1:0] op_q, acc_q, operand;
    logic [5:0]    cnt_q;

    logic [DW-1:0] status, ctrl_rd, rdata_d, rdata_q;
    logic          err_d, err_q, rvalid_q, irq_q;
    logic [IW-1:0] rid_q;

    assign ctrl_wr = req & we & (sel == 2'd3);
    assign in_wr   = req & we & (sel == 2'd0) & ~in_full;
    assign res_pop = req & ~we & (sel == 2'd1);

    // An operand written while the engine is idle and the input FIFO is empty goes straight
    // into the engine, so a lone operand costs no extra cycle in the queue.
    assign can_start = (~in_empty | in_wr) & ~res_full;
    assign operand   = in_empty ? wdata : in_head;
    assign in_pop    = load & ~in_empty;
    assign in_push   = in_wr & ~(load & in_empty);

    bitrev_fifo #(.Depth(Depth), .Width(DW)) u_in_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (in_push),
        .wdata     (wdata),
        .pop       (in_pop),
        .rdata     (in_head),
        .count     (in_count),
        .full      (in_full),
        .empty     (in_empty),
        .empty_nxt (in_empty_nxt_unused)
    );

    bitrev_fifo #(.Depth(Depth), .Width(DW)) u_res_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (res_push),
        .wdata     (acc_q),
        .pop       (res_pop),
        .rdata     (res_head),
        .count     (res_count),
        .full      (res_full),
        .empty     (res_empty),
        .empty_nxt (res_empty_nxt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (can_start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == 6'd1) state_d = ST_PUSH;
            ST_PUSH:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        shift    = 1'b0;
        res_push = 1'b0;
        busy     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                load = can_start;
            end
            ST_SHIFT: shift    = 1'b1;
            ST_PUSH:  res_push = 1'b1;
            default:  busy     = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            op_q  <= operand;
            acc_q <= '0;
            cnt_q <= {1'b0, wsel_q} + 6'd1;
        end else if (shift) begin
            acc_q <= {acc_q[DW-2:0], op_q[0]};
            op_q  <= {1'b0, op_q[DW-1:1]};
            cnt_q <= cnt_q - 6'd1;
        end
    end

    assign irq_en_d = ctrl_wr ? wdata[8] : irq_en_q;

    // irq is a flop of its own next value so it cannot glitch when enable and empty move together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wsel_q   <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) wsel_q <= wdata[4:0];
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & ~res_empty_nxt;
        end
    end

    assign status  = {21'b0, busy, res_empty, in_full, 1'b0, 3'(res_count), 1'b0, 3'(in_count)};
    assign ctrl_rd = {23'b0, irq_en_q, 3'b0, wsel_q};

    always_comb begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (req) begin
            case (sel)
                2'd0: err_d = we ? in_full : 1'b1;
                2'd1: begin
                    if (we || res_empty) err_d = 1'b1;
                    else                 rdata_d = res_head;
                end
                2'd2: begin
                    if (we) err_d = 1'b1;
                    else    rdata_d = status;
                end
                default: if (!we) rdata_d = ctrl_rd;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= req;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rid_q    <= req ? obi_req_i.a.aid : '0;
        end
    end

    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = req;
        obi_rsp_o.rvalid  = rvalid_q;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.rid   = rid_q;
        obi_rsp_o.r.err   = err_q;
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_user_bitrev.sv
// Directed bench for user_bitrev: latency, widths, overflow, interrupt, illegal accesses, reset.

module tb_user_bitrev;

    logic clk_i = 1'b0;
    logic rst_i;
    logic irq_o;
    user_bitrev_pkg::obi_req_t obi_req;
    user_bitrev_pkg::obi_rsp_t obi_rsp;

    int   checks = 0;
    int   errors = 0;
    logic aid_n  = 1'b0;

    logic [31:0] rev_tab [8] = '{32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 32'h2000_0000,
                                 32'hA000_0000, 32'h6000_0000, 32'hE000_0000, 32'h1000_0000};

    always #5 clk_i = ~clk_i;

    user_bitrev dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .obi_req_i (obi_req),
        .obi_rsp_o (obi_rsp),
        .irq_o     (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one request cycle and checks its response one cycle later.
    task automatic access(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        obi_req         = '0;
        obi_req.req     = 1'b1;
        obi_req.a.we    = we;
        obi_req.a.addr  = {28'h0, addr};
        obi_req.a.be    = 4'hF;
        obi_req.a.wdata = wdata;
        obi_req.a.aid   = aid_n;
        #1 chk({tag, ".gnt"}, {31'b0, obi_rsp.gnt}, 32'd1);
        @(negedge clk_i);
        obi_req = '0;
        chk({tag, ".rvalid"}, {31'b0, obi_rsp.rvalid}, 32'd1);
        chk({tag, ".rid"}, {31'b0, obi_rsp.r.rid}, {31'b0, aid_n});
        chk({tag, ".err"}, {31'b0, obi_rsp.r.err}, {31'b0, exp_err});
        chk({tag, ".rdata"}, obi_rsp.r.rdata, exp_rdata);
        aid_n = ~aid_n;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic exp_err,
                      input string tag);
        access(1'b1, addr, data, tag, 32'h0, exp_err);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input logic exp_err,
                      input string tag);
        access(1'b0, addr, 32'h0, tag, exp, exp_err);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        obi_req = '0;
        rst_i   = 1'b1;
        idle(3);
        chk("rst.rvalid", {31'b0, obi_rsp.rvalid}, 32'd0);
        chk("rst.rdata", obi_rsp.r.rdata, 32'd0);
        chk("rst.err", {31'b0, obi_rsp.r.err}, 32'd0);
        chk("rst.rid", {31'b0, obi_rsp.r.rid}, 32'd0);
        chk("rst.irq", {31'b0, irq_o}, 32'd0);
        chk("rst.gnt", {31'b0, obi_rsp.gnt}, 32'd0);
        rst_i = 1'b0;
        idle(1);
        rd(4'hC, 32'h0, 1'b0, "ctrl_rst");
        rd(4'h8, 32'h200, 1'b0, "status_rst");

        // Full width: result readable exactly 34 cycles after the write cycle.
        wr(4'hC, 32'h1F, 1'b0, "fw_ctrl");
        wr(4'h0, 32'h1, 1'b0, "fw_din");
        idle(32);
        rd(4'h8, 32'h600, 1'b0, "fw_status_t33");
        rd(4'h8, 32'h010, 1'b0, "fw_status_t34");
        rd(4'h4, 32'h8000_0000, 1'b0, "fw_result");
        rd(4'h8, 32'h200, 1'b0, "fw_status_drained");

        // Narrow widths, upper operand bits ignored.
        wr(4'hC, 32'h07, 1'b0, "w8_ctrl");
        wr(4'h0, 32'hFFFF_FFB1, 1'b0, "w8_din");
        idle(10);
        rd(4'h4, 32'h8D, 1'b0, "w8_result");
        wr(4'hC, 32'h03, 1'b0, "w4_ctrl");
        wr(4'h0, 32'h6, 1'b0, "w4_din");
        idle(6);
        rd(4'h4, 32'h6, 1'b0, "w4_result");
        wr(4'hC, 32'h0F, 1'b0, "w16_ctrl");
        wr(4'h0, 32'h1234, 1'b0, "w16_din");
        idle(18);
        rd(4'h4, 32'h2C48, 1'b0, "w16_result");
        wr(4'hC, 32'h00, 1'b0, "w1_ctrl");
        wr(4'h0, 32'h3, 1'b0, "w1_din_a");
        idle(3);
        rd(4'h4, 32'h1, 1'b0, "w1_result_a");
        wr(4'h0, 32'h2, 1'b0, "w1_din_b");
        idle(3);
        rd(4'h4, 32'h0, 1'b0, "w1_result_b");
        wr(4'hC, 32'hFFFF_FFFF, 1'b0, "ctrl_all");
        rd(4'hC, 32'h11F, 1'b0, "ctrl_readback");

        // Overflow: 4 results + 4 queued operands, ninth write dropped.
        wr(4'hC, 32'h1F, 1'b0, "ovf_ctrl");
        for (int i = 0; i < 9; i++) begin
            wr(4'h0, 32'(i + 1), (i == 8), "ovf_din");
            idle(39);
        end
        rd(4'h8, 32'h144, 1'b0, "ovf_status");
        for (int i = 0; i < 8; i++) begin
            rd(4'h4, rev_tab[i], 1'b0, "ovf_result");
            idle(39);
        end
        rd(4'h4, 32'h0, 1'b1, "ovf_result_empty");

        // Interrupt rises with the result and falls after the pop.
        wr(4'hC, 32'h11F, 1'b0, "irq_ctrl");
        wr(4'h0, 32'hA5A5_A5A5, 1'b0, "irq_din");
        idle(32);
        chk("irq_before", {31'b0, irq_o}, 32'd0);
        idle(1);
        chk("irq_raised", {31'b0, irq_o}, 32'd1);
        rd(4'h4, 32'hA5A5_A5A5, 1'b0, "irq_result");
        chk("irq_cleared", {31'b0, irq_o}, 32'd0);

        wr(4'hC, 32'h01F, 1'b0, "noirq_ctrl");
        wr(4'h0, 32'h0000_FFFF, 1'b0, "noirq_din");
        idle(40);
        chk("noirq_level", {31'b0, irq_o}, 32'd0);
        rd(4'h8, 32'h010, 1'b0, "noirq_status");

        // Illegal accesses leave the pending result and CTRL intact.
        wr(4'h4, 32'hDEAD, 1'b1, "ill_wr_result");
        wr(4'h8, 32'hBEEF, 1'b1, "ill_wr_status");
        rd(4'h0, 32'h0, 1'b1, "ill_rd_din");
        rd(4'h8, 32'h010, 1'b0, "ill_status_after");
        rd(4'hC, 32'h01F, 1'b0, "ill_ctrl_after");
        rd(4'h4, 32'hFFFF_0000, 1'b0, "ill_result_after");

        // Reset mid-SHIFT, with a request in the reset cycle.
        wr(4'hC, 32'h11F, 1'b0, "rst_ctrl");
        wr(4'h0, 32'h1, 1'b0, "rst_din");
        idle(9);
        obi_req        = '0;
        obi_req.req    = 1'b1;
        obi_req.a.addr = 32'h8;
        obi_req.a.aid  = 1'b1;
        rst_i          = 1'b1;
        #1 chk("rst_mid.rvalid_now", {31'b0, obi_rsp.rvalid}, 32'd0);
        @(negedge clk_i);
        chk("rst_mid.rvalid_next", {31'b0, obi_rsp.rvalid}, 32'd0);
        chk("rst_mid.irq", {31'b0, irq_o}, 32'd0);
        obi_req = '0;
        rst_i   = 1'b0;
        rd(4'h8, 32'h200, 1'b0, "rst_mid_status");
        rd(4'hC, 32'h0, 1'b0, "rst_mid_ctrl");
        idle(40);
        rd(4'h8, 32'h200, 1'b0, "rst_mid_status_late");
        chk("rst_mid.irq_late", {31'b0, irq_o}, 32'd0);
        rd(4'h4, 32'h0, 1'b1, "rst_mid_no_result");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
